// File: rtl/crossbar_write_arbiter.sv
// Per-bank-group round-robin write scheduler for the LSU-to-BG crossbar.
// It back-pressures losing LSUs, honours BG stall, registers collision-free writes, and counts conflict cycles.
module crossbar_write_arbiter #(
  parameter int N_LSU  = 4,
  parameter int N_BG   = 4,
  parameter int W_DATA = 32,
  parameter int W_SEL  = 3
) (
  input  logic                                clk,
  input  logic                                rst_n,
  input  logic [N_LSU*(W_SEL+1+W_DATA)-1:0]   lsu_req_i,
  output logic [N_LSU-1:0]                    lsu_ready_o,
  input  logic [N_BG-1:0]                     bg_stall_i,
  output logic [N_BG*(1+W_DATA)-1:0]          bg_w_o,
  output logic [15:0]                         conflict_cnt_o,
  output logic                                sel_err_o
);

  localparam int W_Q   = W_SEL + 1 + W_DATA;
  localparam int W_BG  = 1 + W_DATA;
  localparam int PTR_W = (N_LSU > 1) ? $clog2(N_LSU) : 1;

  logic [N_LSU-1:0][W_Q-1:0]    req;
  logic [N_LSU-1:0][W_SEL-1:0]  sel;
  logic [N_LSU-1:0]             wen;
  logic [N_LSU-1:0][W_DATA-1:0] data;
  logic [N_LSU-1:0]             sel_ok;
  logic [N_LSU-1:0]             sel_bad;

  logic [N_BG-1:0][N_LSU-1:0]   cand;
  logic [N_BG-1:0]              gnt_valid;
  logic [N_BG-1:0][PTR_W-1:0]   gnt_idx;
  logic [N_LSU-1:0]             lsu_gnt;
  logic                         conflict;

  logic [N_BG-1:0][W_BG-1:0]    bg_w_d,         bg_w_q;
  logic [N_BG-1:0][PTR_W-1:0]   rr_ptr_d,       rr_ptr_q;
  logic [15:0]                  conflict_cnt_d, conflict_cnt_q;
  logic                         sel_err_d,      sel_err_q;

  assign req = lsu_req_i;

  // NOTE: every variable gets a default at the top of always_comb so no path leaves it unassigned (no latch).
  always_comb begin
    sel     = '0;
    wen     = '0;
    data    = '0;
    sel_ok  = '0;
    sel_bad = '0;
    for (int i = 0; i < N_LSU; i++) begin
      sel[i]     = req[i][W_Q-1 -: W_SEL];
      wen[i]     = req[i][W_DATA];
      data[i]    = req[i][W_DATA-1:0];
      sel_ok[i]  = wen[i] && (int'(sel[i]) < N_BG);
      sel_bad[i] = wen[i] && !(int'(sel[i]) < N_BG);
    end
  end

  // Scan candidates starting at each BG's pointer; a stalled BG grants nobody.
  always_comb begin
    logic [PTR_W-1:0] scan_idx;
    scan_idx  = '0;
    cand      = '0;
    gnt_valid = '0;
    gnt_idx   = '0;
    lsu_gnt   = '0;
    for (int b = 0; b < N_BG; b++) begin
      for (int i = 0; i < N_LSU; i++) begin
        cand[b][i] = sel_ok[i] && (sel[i] == W_SEL'(b));
      end
      if (!bg_stall_i[b]) begin
        for (int k = 0; k < N_LSU; k++) begin
          scan_idx = PTR_W'((int'(rr_ptr_q[b]) + k) % N_LSU);
          if (!gnt_valid[b] && cand[b][scan_idx]) begin
            gnt_valid[b] = 1'b1;
            gnt_idx[b]   = scan_idx;
          end
        end
      end
      if (gnt_valid[b]) begin
        lsu_gnt[gnt_idx[b]] = 1'b1;
      end
    end
  end

  assign lsu_ready_o = ~wen | sel_bad | lsu_gnt;
  assign conflict    = |(sel_ok & ~lsu_ready_o);

  always_comb begin
    bg_w_d         = bg_w_q;
    rr_ptr_d       = rr_ptr_q;
    conflict_cnt_d = conflict_cnt_q;
    sel_err_d      = sel_err_q | (|sel_bad);
    for (int b = 0; b < N_BG; b++) begin
      if (!bg_stall_i[b]) begin
        if (gnt_valid[b]) begin
          bg_w_d[b]   = {1'b1, data[gnt_idx[b]]};
          rr_ptr_d[b] = (gnt_idx[b] == PTR_W'(N_LSU - 1)) ? '0 : gnt_idx[b] + PTR_W'(1);
        end else begin
          bg_w_d[b]   = '0;
        end
      end
    end
    if (conflict && (conflict_cnt_q != 16'hFFFF)) begin
      conflict_cnt_d = conflict_cnt_q + 16'd1;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bg_w_q         <= '0;
      rr_ptr_q       <= '0;
      conflict_cnt_q <= '0;
      sel_err_q      <= 1'b0;
    end else begin
      bg_w_q         <= bg_w_d;
      rr_ptr_q       <= rr_ptr_d;
      conflict_cnt_q <= conflict_cnt_d;
      sel_err_q      <= sel_err_d;
    end
  end

  assign bg_w_o         = bg_w_q;
  assign conflict_cnt_o = conflict_cnt_q;
  assign sel_err_o      = sel_err_q;

endmodule

// File: tb/tb_crossbar_write_arbiter.sv
// Directed bench for crossbar_write_arbiter: one task per scenario, inline comparisons against hand-computed values.
module tb_crossbar_write_arbiter;

  localparam int N_LSU  = 4;
  localparam int N_BG   = 4;
  localparam int W_DATA = 32;
  localparam int W_SEL  = 3;
  localparam int W_Q    = W_SEL + 1 + W_DATA;
  localparam int W_BG   = 1 + W_DATA;

  logic                    clk = 1'b0;
  logic                    rst_n;
  logic [N_LSU*W_Q-1:0]    lsu_req;
  logic [N_LSU-1:0]        lsu_ready;
  logic [N_BG-1:0]         bg_stall;
  logic [N_BG*W_BG-1:0]    bg_w;
  logic [15:0]             conflict_cnt;
  logic                    sel_err;

  int n_pass  = 0;
  int n_total = 0;

  crossbar_write_arbiter #(
    .N_LSU (N_LSU),
    .N_BG  (N_BG),
    .W_DATA(W_DATA),
    .W_SEL (W_SEL)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .lsu_req_i     (lsu_req),
    .lsu_ready_o   (lsu_ready),
    .bg_stall_i    (bg_stall),
    .bg_w_o        (bg_w),
    .conflict_cnt_o(conflict_cnt),
    .sel_err_o     (sel_err)
  );

  always #5 clk = ~clk;

  task automatic set_req(input int i, input logic [W_SEL-1:0] sel, input logic wen,
                         input logic [W_DATA-1:0] data);
    lsu_req[i*W_Q +: W_Q] = {sel, wen, data};
  endtask

  function automatic logic [W_BG-1:0] bg(input int b);
    return bg_w[b*W_BG +: W_BG];
  endfunction

  function automatic logic [W_BG-1:0] wr(input logic [W_DATA-1:0] d);
    return {1'b1, d};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset();
    rst_n    = 1'b0;
    lsu_req  = '0;
    bg_stall = '0;
    tick();
    tick();
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    rst_n    = 1'b0;
    lsu_req  = '0;
    bg_stall = '0;
    #3;
    n_total++;
    if (bg_w !== '0) $display("FAIL reset_bg_w: got %h expected 0", bg_w);
    else n_pass++;
    n_total++;
    if (conflict_cnt !== 16'h0) $display("FAIL reset_cnt: got %h expected 0", conflict_cnt);
    else n_pass++;
    n_total++;
    if (sel_err !== 1'b0) $display("FAIL reset_sel_err: got %b expected 0", sel_err);
    else n_pass++;
    n_total++;
    if (lsu_ready !== 4'hF) $display("FAIL reset_ready_idle: got %b expected 1111", lsu_ready);
    else n_pass++;
    tick();
    rst_n = 1'b1;
  endtask

  task automatic test_no_conflict();
    apply_reset();
    for (int i = 0; i < 4; i++) set_req(i, W_SEL'(i), 1'b1, 32'hA0 + i);
    #1;
    n_total++;
    if (lsu_ready !== 4'hF) $display("FAIL perm_ready: got %b expected 1111", lsu_ready);
    else n_pass++;
    tick();
    for (int b = 0; b < 4; b++) begin
      n_total++;
      if (bg(b) !== wr(32'hA0 + b)) $display("FAIL perm_bg%0d: got %h expected %h", b, bg(b), wr(32'hA0 + b));
      else n_pass++;
    end
    n_total++;
    if (conflict_cnt !== 16'd0) $display("FAIL perm_cnt: got %0d expected 0", conflict_cnt);
    else n_pass++;
    lsu_req = '0;
    tick();
    n_total++;
    if (bg_w !== '0) $display("FAIL perm_pulse_end: got %h expected 0", bg_w);
    else n_pass++;
  endtask

  task automatic test_round_robin();
    logic [3:0] exp_rdy;
    apply_reset();
    for (int i = 0; i < 4; i++) set_req(i, 3'd2, 1'b1, 32'hB0 + i);
    for (int c = 0; c < 4; c++) begin
      #1;
      exp_rdy = 4'((1 << (c + 1)) - 1);
      n_total++;
      if (lsu_ready !== exp_rdy) $display("FAIL rr_ready_c%0d: got %b expected %b", c, lsu_ready, exp_rdy);
      else n_pass++;
      tick();
      n_total++;
      if (bg(2) !== wr(32'hB0 + c)) $display("FAIL rr_bg2_c%0d: got %h expected %h", c, bg(2), wr(32'hB0 + c));
      else n_pass++;
      set_req(c, 3'd0, 1'b0, 32'h0);
    end
    n_total++;
    if (conflict_cnt !== 16'd3) $display("FAIL rr_cnt: got %0d expected 3", conflict_cnt);
    else n_pass++;
    // Pointer has wrapped to 0, so LSU0 beats LSU3.
    set_req(0, 3'd2, 1'b1, 32'hE0);
    set_req(3, 3'd2, 1'b1, 32'hE3);
    #1;
    n_total++;
    if (lsu_ready !== 4'b0111) $display("FAIL rr_wrap_ready: got %b expected 0111", lsu_ready);
    else n_pass++;
    tick();
    n_total++;
    if (bg(2) !== wr(32'hE0)) $display("FAIL rr_wrap_bg2: got %h expected %h", bg(2), wr(32'hE0));
    else n_pass++;
    lsu_req = '0;
  endtask

  task automatic test_stall_hold();
    apply_reset();
    set_req(0, 3'd1, 1'b1, 32'h11);
    tick();
    n_total++;
    if (bg(1) !== wr(32'h11)) $display("FAIL stall_prior: got %h expected %h", bg(1), wr(32'h11));
    else n_pass++;
    set_req(0, 3'd0, 1'b0, 32'h0);
    set_req(1, 3'd1, 1'b1, 32'h55);
    bg_stall = 4'b0010;
    for (int c = 0; c < 3; c++) begin
      #1;
      n_total++;
      if (lsu_ready[1] !== 1'b0) $display("FAIL stall_ready_c%0d: got %b expected 0", c, lsu_ready[1]);
      else n_pass++;
      tick();
      n_total++;
      if (bg(1) !== wr(32'h11)) $display("FAIL stall_hold_c%0d: got %h expected %h", c, bg(1), wr(32'h11));
      else n_pass++;
    end
    bg_stall = '0;
    #1;
    n_total++;
    if (lsu_ready[1] !== 1'b1) $display("FAIL stall_release_ready: got %b expected 1", lsu_ready[1]);
    else n_pass++;
    tick();
    n_total++;
    if (bg(1) !== wr(32'h55)) $display("FAIL stall_write: got %h expected %h", bg(1), wr(32'h55));
    else n_pass++;
    n_total++;
    if (conflict_cnt !== 16'd3) $display("FAIL stall_cnt: got %0d expected 3", conflict_cnt);
    else n_pass++;
    lsu_req = '0;
    tick();
    n_total++;
    if (bg(1) !== '0) $display("FAIL stall_pulse_end: got %h expected 0", bg(1));
    else n_pass++;
  endtask

  task automatic test_invalid_sel();
    apply_reset();
    set_req(2, 3'd5, 1'b1, 32'hDEAD);
    #1;
    n_total++;
    if (lsu_ready !== 4'hF) $display("FAIL badsel_ready: got %b expected 1111", lsu_ready);
    else n_pass++;
    n_total++;
    if (sel_err !== 1'b0) $display("FAIL badsel_err_early: got %b expected 0", sel_err);
    else n_pass++;
    tick();
    n_total++;
    if (sel_err !== 1'b1) $display("FAIL badsel_err: got %b expected 1", sel_err);
    else n_pass++;
    n_total++;
    if (bg_w !== '0) $display("FAIL badsel_no_write: got %h expected 0", bg_w);
    else n_pass++;
    n_total++;
    if (conflict_cnt !== 16'd0) $display("FAIL badsel_cnt: got %0d expected 0", conflict_cnt);
    else n_pass++;
    lsu_req = '0;
    tick();
    tick();
    n_total++;
    if (sel_err !== 1'b1) $display("FAIL badsel_sticky: got %b expected 1", sel_err);
    else n_pass++;
  endtask

  task automatic test_reset_mid();
    apply_reset();
    set_req(0, 3'd0, 1'b1, 32'hC0);
    set_req(2, 3'd7, 1'b1, 32'h0);
    tick();
    n_total++;
    if (bg(0) !== wr(32'hC0) || sel_err !== 1'b1)
      $display("FAIL mid_setup: got bg0=%h err=%b expected %h 1", bg(0), sel_err, wr(32'hC0));
    else n_pass++;
    // Stall BG0 one cycle so the pointer stays at 1 while the counter moves.
    set_req(2, 3'd0, 1'b0, 32'h0);
    set_req(0, 3'd0, 1'b1, 32'hD0);
    set_req(3, 3'd0, 1'b1, 32'hD3);
    bg_stall = 4'b0001;
    #1;
    n_total++;
    if (lsu_ready !== 4'b0110) $display("FAIL mid_stall_ready: got %b expected 0110", lsu_ready);
    else n_pass++;
    tick();
    n_total++;
    if (conflict_cnt !== 16'd1) $display("FAIL mid_cnt: got %0d expected 1", conflict_cnt);
    else n_pass++;
    bg_stall = '0;
    #1;
    n_total++;
    if (lsu_ready !== 4'b1110) $display("FAIL mid_ptr1_ready: got %b expected 1110", lsu_ready);
    else n_pass++;
    rst_n = 1'b0;
    #1;
    n_total++;
    if (bg_w !== '0 || conflict_cnt !== 16'd0 || sel_err !== 1'b0)
      $display("FAIL mid_async_clear: got bg=%h cnt=%0d err=%b expected 0 0 0", bg_w, conflict_cnt, sel_err);
    else n_pass++;
    n_total++;
    if (lsu_ready !== 4'b0111) $display("FAIL mid_reset_ready: got %b expected 0111", lsu_ready);
    else n_pass++;
    tick();
    n_total++;
    if (bg_w !== '0) $display("FAIL mid_no_update: got %h expected 0", bg_w);
    else n_pass++;
    rst_n = 1'b1;
    tick();
    n_total++;
    if (bg(0) !== wr(32'hD0)) $display("FAIL mid_first_grant: got %h expected %h", bg(0), wr(32'hD0));
    else n_pass++;
    set_req(0, 3'd0, 1'b0, 32'h0);
    tick();
    n_total++;
    if (bg(0) !== wr(32'hD3)) $display("FAIL mid_second_grant: got %h expected %h", bg(0), wr(32'hD3));
    else n_pass++;
    n_total++;
    if (conflict_cnt !== 16'd1) $display("FAIL mid_cnt_after: got %0d expected 1", conflict_cnt);
    else n_pass++;
    lsu_req = '0;
  endtask

  task automatic test_saturation();
    apply_reset();
    set_req(0, 3'd0, 1'b1, 32'h1);
    bg_stall = 4'b0001;
    repeat (65534) tick();
    n_total++;
    if (conflict_cnt !== 16'hFFFE) $display("FAIL sat_pre: got %h expected fffe", conflict_cnt);
    else n_pass++;
    tick();
    n_total++;
    if (conflict_cnt !== 16'hFFFF) $display("FAIL sat_reach: got %h expected ffff", conflict_cnt);
    else n_pass++;
    repeat (4465) tick();
    n_total++;
    if (conflict_cnt !== 16'hFFFF) $display("FAIL sat_hold: got %h expected ffff", conflict_cnt);
    else n_pass++;
    n_total++;
    if (bg(0) !== '0) $display("FAIL sat_bg0: got %h expected 0", bg(0));
    else n_pass++;
    lsu_req  = '0;
    bg_stall = '0;
  endtask

  initial begin
    test_reset();
    test_no_conflict();
    test_round_robin();
    test_stall_hold();
    test_invalid_sel();
    test_reset_mid();
    test_saturation();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/crossbar_write_arbiter.md
# crossbar_write_arbiter

Conflict-resolving write scheduler placed in front of the 4x4 write crossbar between the LSUs and the bank groups (BGs). The crossbar itself resolves same-BG collisions by fixed priority and silently drops the losers. This block instead arbitrates per BG with a round-robin pointer, back-pressures losing LSUs with a ready handshake, and honours per-BG stall. It drives registered, collision-free `{Wen, data}` words to each BG and keeps a saturating conflict-cycle counter for performance monitoring.

## Interface
Parameters:
- `N_LSU`, 4: number of LSU write requesters.
- `N_BG`, 4: number of bank groups.
- `W_DATA`, 32: write data width.
- `W_SEL`, 3: BG select width. `W_Q = W_SEL+1+W_DATA` = 36.

Ports:
- `clk`  in  1  single clock, rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `lsu_req_i`  in  `N_LSU*W_Q`  request `i` at `[i*W_Q +: W_Q]`, packed `{sel[W_SEL-1:0], wen, data[W_DATA-1:0]}`.
- `lsu_ready_o`  out  `N_LSU`  combinational accept; request `i` is consumed in a cycle where `wen_i && lsu_ready_o[i]`.
- `bg_stall_i`  in  `N_BG`  BG `b` cannot take a write this cycle.
- `bg_w_o`  out  `N_BG*(1+W_DATA)`  BG `b` at `[b*(1+W_DATA) +: 1+W_DATA]` = `{Wen, data}`, registered.
- `conflict_cnt_o`  out  16  saturating count of cycles with at least one stalled valid request.
- `sel_err_o`  out  1  sticky: a request targeted `sel >= N_BG`.

## Operation
- A request is valid iff `wen == 1`. If `wen == 0`, `sel` and `data` are ignored and `lsu_ready_o[i] = 1`.
- Invalid target (`wen=1`, `sel >= N_BG`):
  - `lsu_ready_o[i] = 1`; the request is consumed and dropped.
  - `sel_err_o` sets on the next edge and holds until reset.
  - The request does not count as a conflict.
- Candidates of BG `b`: all LSUs with a valid request and `sel == b`.
- Per-BG round-robin:
  - Pointer `rr_ptr[b]` (`clog2(N_LSU)` bits).
  - Grant goes to the first candidate found scanning `rr_ptr[b], rr_ptr[b]+1, …` modulo `N_LSU`.
  - On a grant to LSU `g`, `rr_ptr[b] <= (g+1) mod N_LSU`. The pointer is unchanged when there is no grant.
- Stall: if `bg_stall_i[b] = 1`:
  - no grant for BG `b`;
  - `rr_ptr[b]` and `bg_w_o[b]` hold their values;
  - all candidates of `b` see ready low.
- `lsu_ready_o[i] = 1` iff LSU `i` is invalid, targets an invalid BG, or is granted. Each LSU targets at most one BG per cycle, so at most one grant per LSU.
- Output register, per BG, not stalled:
  - on a grant to `g`: `bg_w_o[b] <= {1'b1, data_g}`;
  - with no candidate: `bg_w_o[b] <= {1'b0, {W_DATA{1'b0}}}`.
- Each `bg_w_o[b]` is a single-cycle write pulse unless the BG is stalled. A stall freezes the register, so the BG must ignore `bg_w_o` while it asserts stall.
- `conflict_cnt_o` increments by 1 in any cycle where some LSU has a valid, valid-target request with ready low. This covers both lost arbitration and stall. The count saturates at `16'hFFFF`.
- LSUs must hold their request stable while ready is low. The block does not check this.

## Timing
- Reset (asynchronous assert, synchronous deassert by the environment):
  - `bg_w_o = 0`, `rr_ptr = 0`, `conflict_cnt_o = 0`, `sel_err_o = 0`.
  - `lsu_ready_o` stays combinational during reset; requests presented then are not consumed (no state updates).
- Latency: request accepted in cycle T appears on `bg_w_o` in T+1.
- Throughput: one write per BG per cycle. A full permutation of 4 LSUs onto 4 BGs is all accepted in one cycle.
- Ready depends combinationally on `lsu_req_i`, `bg_stall_i` and `rr_ptr`; there is no path from `lsu_ready_o` back into `lsu_req_i` inside the block.
- Simultaneous events:
  - stall and grant pressure on the same BG in the same cycle: stall wins;
  - pointer wrap: from `N_LSU-1` the pointer goes to 0;
  - counter at `16'hFFFF` with a conflict: holds.
- Reset mid-operation: pending un-granted requests are re-arbitrated from `rr_ptr = 0` after release. No output is replayed.

## Test plan
- **No conflict.** LSU0..3 send `sel` = 0,1,2,3 with data `0xA0..0xA3`.
  - Cycle T: all four `lsu_ready_o` = 1.
  - Cycle T+1: `bg_w_o[b] = {1, 0xA0+b}`; `conflict_cnt_o = 0`.
- **Round-robin fairness.** All four LSUs hold `sel=2` and retire on ready.
  - Grant order is 0, 1, 2, 3 over 4 cycles; BG2 sees data in that order.
  - `conflict_cnt_o = 3` after the last grant; `rr_ptr[2]` wraps to 0.
- **Stall hold.** LSU1 targets BG1 with `0x55`; `bg_stall_i[1] = 1` for 3 cycles, then drops.
  - Ready is low for 3 cycles; `bg_w_o[1]` holds its prior value.
  - The write of `0x55` appears one cycle after stall release.
  - `conflict_cnt_o` increases by 3.
- **Invalid select.** LSU2 sends `sel = 5`, `wen = 1`.
  - Ready = 1 the same cycle; no BG is written.
  - `sel_err_o = 1` the next cycle and stays set.
- **Reset mid-operation.** Assert `rst_n = 0` while LSU0 and LSU3 contend for BG0 with `rr_ptr[0] = 1`.
  - `bg_w_o`, the counter and `sel_err_o` clear immediately.
  - After release, LSU0 is granted first.
- **Counter saturation.** Force 70000 continuous conflict cycles.
  - `conflict_cnt_o` reaches `0xFFFF` and stays there.
